imem_loader: RTL

- Writer side of the instruction-memory port; the core only ever reads imem.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian words, and writes them sequentially into imem through its write port (we_in/data_in/address_in).
- Holds the core in reset through core_nrst_out until the image is complete, then releases it.
- Sits between a host/byte source and imem at the top level, beside the core.

---
 rtl/imem_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader that fills instruction memory and holds the core in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int INDEX = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    output logic             byte_ready_out,
    input  logic             reload_in,
    output logic             imem_we_out,
    output logic [INDEX-1:0] imem_addr_out,
    output logic [WIDTH-1:0] imem_data_out,
    output logic             core_nrst_out,
    output logic             done_out,
    output logic             error_out,
    output logic [INDEX:0]   words_loaded_out
);

    localparam int BYTES = WIDTH / 8;
    localparam int DEPTH = 2 ** INDEX;
    localparam int SW    = (WIDTH > 32) ? WIDTH : 32;
    localparam int CW    = $clog2(SW / 8) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;
    localparam state_t S_AFTER = S_CHECK;
`else
    typedef enum logic [2:0] {S_LEN, S_LOAD, S_DONE, S_ERROR} state_t;
    localparam state_t S_AFTER = S_DONE;
`endif

    state_t           r_state;
    logic [CW-1:0]    r_byte_cnt;
    logic [INDEX:0]   r_word_cnt;
    logic [INDEX:0]   r_target;
    logic [SW-1:0]    r_shift;
    logic [7:0]       r_sum;
    logic             r_we;
    logic [INDEX-1:0] r_addr;
    logic [WIDTH-1:0] r_data;
    logic             r_done;
    logic             r_nrst;
    logic             r_error;

    logic             w_ready;
    logic             w_accept;
    logic [SW-1:0]    w_shift_next;
    logic [31:0]      w_len;
    logic             w_len_too_big;
    logic [INDEX:0]   w_word_cnt_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_ready = (r_state == S_LEN) || (r_state == S_LOAD) || (r_state == S_CHECK);
`else
    assign w_ready = (r_state == S_LEN) || (r_state == S_LOAD);
`endif
    assign w_accept = byte_valid_in && w_ready;

    // Little-endian assembly: the byte counter selects which lane the incoming byte fills.
    always_comb begin
        w_shift_next = r_shift;
        w_shift_next[{r_byte_cnt, 3'b000} +: 8] = byte_in;
    end

    assign w_len           = w_shift_next[31:0];
    assign w_len_too_big   = {1'b0, w_len} > 33'(DEPTH);
    assign w_word_cnt_next = r_word_cnt + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_LEN;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_target   <= '0;
            r_shift    <= '0;
            r_sum      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_nrst     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_accept) begin
                        if (r_byte_cnt == CW'(3)) begin
                            r_byte_cnt <= '0;
                            r_shift    <= '0;
                            r_target   <= w_len[INDEX:0];
                            if (w_len_too_big) begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else if (w_len == 32'd0) begin
                                r_state <= S_AFTER;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_shift    <= w_shift_next;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_sum <= r_sum ^ byte_in;
                        if (r_byte_cnt == CW'(BYTES - 1)) begin
                            r_byte_cnt <= '0;
                            r_shift    <= '0;
                            r_we       <= 1'b1;
                            r_data     <= w_shift_next[WIDTH-1:0];
                            r_addr     <= r_word_cnt[INDEX-1:0];
                            r_word_cnt <= w_word_cnt_next;
                            if (w_word_cnt_next == r_target) begin
                                r_state <= S_AFTER;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_shift    <= w_shift_next;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        if (byte_in == r_sum) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                // Release lags state entry by one edge so it never overlaps the last write pulse.
                S_DONE, S_ERROR: begin
                    if (reload_in) begin
                        r_state    <= S_LEN;
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_shift    <= '0;
                        r_sum      <= '0;
                        r_done     <= 1'b0;
                        r_nrst     <= 1'b0;
                        r_error    <= 1'b0;
                    end else if (r_state == S_DONE) begin
                        r_done <= 1'b1;
                        r_nrst <= 1'b1;
                    end
                end
                default: r_state <= S_LEN;
            endcase
        end
    end

    assign byte_ready_out   = w_ready;
    assign imem_we_out      = r_we;
    assign imem_addr_out    = r_addr;
    assign imem_data_out    = r_data;
    assign core_nrst_out    = r_nrst;
    assign done_out         = r_done;
    assign error_out        = r_error;
    assign words_loaded_out = r_word_cnt;

endmodule
